// File: rtl/pulse_event_queue.sv
// pulse_event_queue
//   Fast-domain front end for the three-channel pulse synchronizer. Counts single-cycle event
//   pulses per channel and replays them as single-cycle pulses on sig_out only while the
//   synchronizer reports idle (busy_in low), so no event is lost while it is busy.
//
// Ports
//   clk          single clock, all logic on the rising edge
//   rst          asynchronous active-low reset
//   event_in     per-channel event pulses; a level held N cycles counts as N events
//   busy_in      synchronizer busy level (same clock domain)
//   ovf_clr      clears the overflow and arm_timeout sticky flags
//   sig_out      registered single-cycle pulses to the synchronizer
//   pending      registered; bit i set while channel i's counter is nonzero
//   overflow     sticky; an event was dropped on a saturated counter
//   arm_timeout  sticky; busy_in did not rise within HOLD_CYC cycles after an issue
//
// Configuration
//   PEQ_ROUND_ROBIN_ISSUE_EN  when defined, each issue selects one channel, the first nonzero
//                             channel at or after a rotating pointer. Otherwise all nonzero
//                             channels are issued together.

module pulse_event_queue #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned HOLD_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] event_in,
  input  logic       busy_in,
  input  logic       ovf_clr,
  output logic [2:0] sig_out,
  output logic [2:0] pending,
  output logic       overflow,
  output logic       arm_timeout
);

  localparam int unsigned HoldW = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYC - 1);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StArm, StDrain} state_e;

  state_e           state_q;
  logic [HoldW-1:0] hold_q;
  logic [2:0]       sig_out_q;
  logic             arm_timeout_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       pending_q, pending_d;
  logic             overflow_q;
  logic             ovf_set;
  logic [2:0]       nz;
  logic [2:0]       sel;
  logic [2:0]       dec;
  logic             issue;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nz[i] = (cnt_q[i] != '0);
    end
  end

  // Issue decision uses the registered counts; an event arriving this cycle is issued later.
  assign issue = (state_q == StIdle) && (|nz) && !busy_in;

`ifdef PEQ_ROUND_ROBIN_ISSUE_EN
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  // First nonzero channel at or after the pointer.
  always_comb begin
    sel = 3'b000;
    unique case (ptr_q)
      2'd1: begin
        if (nz[1])      sel = 3'b010;
        else if (nz[2]) sel = 3'b100;
        else if (nz[0]) sel = 3'b001;
      end
      2'd2: begin
        if (nz[2])      sel = 3'b100;
        else if (nz[0]) sel = 3'b001;
        else if (nz[1]) sel = 3'b010;
      end
      default: begin
        if (nz[0])      sel = 3'b001;
        else if (nz[1]) sel = 3'b010;
        else if (nz[2]) sel = 3'b100;
      end
    endcase
  end

  // Pointer moves to the channel after the one issued.
  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      unique case (sel)
        3'b001:  ptr_d = 2'd1;
        3'b010:  ptr_d = 2'd2;
        default: ptr_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign sel = nz;
`endif

  assign dec = issue ? sel : 3'b000;

  // Event and decrement together cancel, which also keeps a saturated counter from overflowing.
  always_comb begin
    ovf_set = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (event_in[i] && !dec[i]) begin
        if (cnt_q[i] == CntMax) begin
          ovf_set = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end else if (dec[i] && !event_in[i]) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
      pending_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      pending_q  <= 3'b000;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pending_q  <= pending_d;
      overflow_q <= (overflow_q & ~ovf_clr) | ovf_set;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      sig_out_q     <= 3'b000;
      arm_timeout_q <= 1'b0;
    end else begin
      sig_out_q     <= 3'b000;
      // A timeout set below overrides a simultaneous clear.
      arm_timeout_q <= arm_timeout_q & ~ovf_clr;
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            state_q   <= StIssue;
            sig_out_q <= sel;
          end
        end
        StIssue: begin
          state_q <= StArm;
          hold_q  <= '0;
        end
        StArm: begin
          if (busy_in) begin
            state_q <= StDrain;
          end else if (hold_q == HoldLast) begin
            arm_timeout_q <= 1'b1;
            state_q       <= StIdle;
          end else begin
            hold_q <= hold_q + HoldOne;
          end
        end
        StDrain: begin
          if (!busy_in) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sig_out     = sig_out_q;
  assign pending     = pending_q;
  assign overflow    = overflow_q;
  assign arm_timeout = arm_timeout_q;

endmodule

// File: tb/tb_pulse_event_queue.sv
// Scoreboarded random bench for pulse_event_queue. The stimulus process drives events, busy and
// ovf_clr at the falling edge, steps a behavioural model and pushes the expected sig_out pulse
// and status for the coming rising edge; a monitor pops and compares just after each edge.

module tb_pulse_event_queue;

  localparam int unsigned CntW    = 4;
  localparam int unsigned HoldCyc = 3;
  localparam int          Sat     = (1 << CntW) - 1;

  logic       clk;
  logic       rst;
  logic [2:0] event_in;
  logic       busy_in;
  logic       ovf_clr;
  logic [2:0] sig_out;
  logic [2:0] pending;
  logic       overflow;
  logic       arm_timeout;

  pulse_event_queue #(
    .CNT_W    (CntW),
    .HOLD_CYC (HoldCyc)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .event_in    (event_in),
    .busy_in     (busy_in),
    .ovf_clr     (ovf_clr),
    .sig_out     (sig_out),
    .pending     (pending),
    .overflow    (overflow),
    .arm_timeout (arm_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] mask;
  } pulse_t;

  typedef struct {
    int         cyc;
    logic [2:0] pend;
    logic       ovf;
    logic       tmo;
  } stat_t;

  pulse_t pulse_q [$];
  stat_t  stat_q  [$];

  int n_vec  = 0;
  int n_err  = 0;
  int edge_n = 0;
  bit mon_en = 1'b0;

  // Reference model: plain per-channel event counts plus "free to issue" bookkeeping.
  int cnt_m [3];
  bit ready_m;
  int since_m;
  bit busy_seen_m;
  bit ovf_m;
  bit tmo_m;
  int rr_m;

  // Synchronizer stand-in and stimulus knobs.
  bit force_busy;
  int b_wait;
  int b_left;
  int ev_pct;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) cnt_m[i] = 0;
    ready_m     = 1'b1;
    since_m     = 0;
    busy_seen_m = 1'b0;
    ovf_m       = 1'b0;
    tmo_m       = 1'b0;
    rr_m        = 0;
    b_wait      = -1;
    b_left      = 0;
  endtask

  // What the next rising edge should do, given the inputs that edge will sample.
  task automatic model_edge(input logic [2:0] ev, input logic b, input logic clr);
    logic [2:0] iss;
    logic [2:0] pend;
    bit         ovf_set;
    bit         tmo_set;
    int         c;
    iss     = 3'b000;
    pend    = 3'b000;
    ovf_set = 1'b0;
    tmo_set = 1'b0;
    if (ready_m) begin
      if (!b && (cnt_m[0] > 0 || cnt_m[1] > 0 || cnt_m[2] > 0)) begin
`ifdef PEQ_ROUND_ROBIN_ISSUE_EN
        for (int k = 0; k < 3; k++) begin
          c = (rr_m + k) % 3;
          if (cnt_m[c] > 0) begin
            iss  = 3'(1 << c);
            rr_m = (c + 1) % 3;
            break;
          end
        end
`else
        for (int k = 0; k < 3; k++) begin
          c = k;
          if (cnt_m[c] > 0) iss = iss | 3'(1 << c);
        end
`endif
        ready_m     = 1'b0;
        since_m     = 0;
        busy_seen_m = 1'b0;
        pulse_q.push_back('{edge_n + 1, iss});
      end
    end else begin
      since_m++;
      // The edge right after the pulse only moves on; busy counts from the edge after that.
      if (since_m >= 2) begin
        if (!busy_seen_m) begin
          if (b) begin
            busy_seen_m = 1'b1;
          end else if (since_m - 1 == int'(HoldCyc)) begin
            tmo_set = 1'b1;
            ready_m = 1'b1;
          end
        end else if (!b) begin
          ready_m = 1'b1;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (ev[i] && !iss[i]) begin
        if (cnt_m[i] == Sat) ovf_set = 1'b1;
        else cnt_m[i]++;
      end else if (iss[i] && !ev[i]) begin
        cnt_m[i]--;
      end
      if (cnt_m[i] != 0) pend = pend | 3'(1 << i);
    end
    ovf_m = (ovf_m && !clr) || ovf_set;
    tmo_m = (tmo_m && !clr) || tmo_set;
    stat_q.push_back('{edge_n + 1, pend, ovf_m, tmo_m});
  endtask

  // One falling-edge worth of stimulus: busy stand-in, events, clear, then the model step.
  task automatic step_body(input bit use_ov, input logic [2:0] ev_ov);
    logic [2:0] ev;
    if (sig_out != 3'b000 && $urandom_range(0, 5) != 0) b_wait = $urandom_range(0, 2);
    if (b_wait == 0) begin
      b_left = $urandom_range(1, 4);
      b_wait = -1;
    end else if (b_wait > 0) begin
      b_wait--;
    end
    busy_in = (b_left > 0) || force_busy;
    if (b_left > 0) b_left--;
    ev = 3'b000;
    if (use_ov) begin
      ev = ev_ov;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (int'($urandom_range(0, 99)) < ev_pct) ev = ev | 3'(1 << i);
      end
    end
    event_in = ev;
    ovf_clr  = ($urandom_range(0, 19) == 0);
    model_edge(ev, busy_in, ovf_clr);
  endtask

  task automatic cycle(input bit use_ov, input logic [2:0] ev_ov);
    @(negedge clk);
    step_body(use_ov, ev_ov);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin : mon
      logic [2:0] exp_sig;
      stat_t      st;
      exp_sig = 3'b000;
      if (pulse_q.size() > 0 && pulse_q[0].cyc == edge_n) begin
        exp_sig = pulse_q[0].mask;
        void'(pulse_q.pop_front());
      end
      chk("sig_out", 32'(sig_out), 32'(exp_sig));
      if (stat_q.size() > 0 && stat_q[0].cyc == edge_n) begin
        st = stat_q.pop_front();
        chk("pending", 32'(pending), 32'(st.pend));
        chk("overflow", 32'(overflow), 32'(st.ovf));
        chk("arm_timeout", 32'(arm_timeout), 32'(st.tmo));
      end else begin
        chk("status_entry_present", 32'(0), 32'(1));
      end
    end
  end

  initial begin : stim
    bit got;
    rst        = 1'b0;
    event_in   = 3'b000;
    busy_in    = 1'b0;
    ovf_clr    = 1'b0;
    force_busy = 1'b0;
    ev_pct     = 0;
    model_reset();
    #1;
    chk("reset_sig_out", 32'(sig_out), 32'(0));
    chk("reset_pending", 32'(pending), 32'(0));
    chk("reset_overflow", 32'(overflow), 32'(0));
    chk("reset_arm_timeout", 32'(arm_timeout), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
    step_body(1'b1, 3'b000);

    // Sparse traffic, including a lone ch1 event and a simultaneous ch0+ch2 pair.
    cycle(1'b1, 3'b010);
    for (int i = 0; i < 10; i++) cycle(1'b1, 3'b000);
    cycle(1'b1, 3'b101);
    ev_pct = 10;
    for (int i = 0; i < 60; i++) cycle(1'b0, 3'b000);

    // Held busy with heavy traffic: counters saturate and overflow sets.
    force_busy = 1'b1;
    ev_pct     = 50;
    for (int i = 0; i < 40; i++) cycle(1'b0, 3'b000);
    for (int i = 0; i < 20; i++) cycle(1'b1, 3'b100);
    force_busy = 1'b0;
    ev_pct     = 0;
    for (int i = 0; i < 500; i++) cycle(1'b0, 3'b000);

    // Mixed traffic with busy stretches.
    ev_pct = 15;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) force_busy = !force_busy;
      cycle(1'b0, 3'b000);
    end
    force_busy = 1'b0;
    ev_pct     = 0;
    for (int i = 0; i < 600; i++) cycle(1'b0, 3'b000);

    // Reset while a ch1 pulse is on sig_out with more ch1 events still queued.
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'b010);
    force_busy = 1'b0;
    got        = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      cycle(1'b1, 3'b000);
      got = (pulse_q.size() > 0);
    end
    chk("issue_before_reset_seen", 32'(got), 32'(1));
    @(posedge clk);
    #2;
    rst      = 1'b0;
    mon_en   = 1'b0;
    event_in = 3'b000;
    busy_in  = 1'b0;
    ovf_clr  = 1'b0;
    #1;
    chk("async_reset_sig_out", 32'(sig_out), 32'(0));
    chk("async_reset_pending", 32'(pending), 32'(0));
    pulse_q.delete();
    stat_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
    step_body(1'b1, 3'b000);
    for (int i = 0; i < 30; i++) cycle(1'b1, 3'b000);

    ev_pct = 20;
    for (int i = 0; i < 300; i++) cycle(1'b0, 3'b000);
    ev_pct = 0;
    for (int i = 0; i < 600; i++) cycle(1'b0, 3'b000);

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("expected_pulses_consumed", 32'(pulse_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_event_queue.md
# pulse_event_queue

Fast-domain front end for the three-channel pulse synchronizer. Accepts single-cycle event pulses on three channels at any rate, counts them per channel, and replays them as single-cycle pulses only while the synchronizer reports idle. Prevents event loss from pulses arriving while the synchronizer is busy. Sits in the `clk_a` domain, directly upstream of the synchronizer's `sig_3bit`/`busy` pair.

## Interface
Parameters:
- `CNT_W`, default 4: width of each per-channel pending counter; saturates at 2^CNT_W-1.
- `HOLD_CYC`, default 3: maximum cycles to wait for `busy_in` to rise after an issue before giving up.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `event_in`  in  3  per-channel single-cycle event pulses; a level held N cycles counts as N events.
- `busy_in`  in  1  synchronizer busy, level, same clock domain.
- `ovf_clr`  in  1  clears `overflow` and `arm_timeout`.
- `sig_out`  out  3  registered single-cycle pulses to the synchronizer.
- `pending`  out  3  registered; bit i = counter i nonzero.
- `overflow`  out  1  sticky; an event was dropped on a saturated counter.
- `arm_timeout`  out  1  sticky; `busy_in` did not rise within `HOLD_CYC` after an issue.

## Operation
- Per-channel counter `cnt[i]`, CNT_W bits.
  - `event_in[i]` alone: increment.
  - Issue decrement alone: decrement.
  - Both in the same cycle: unchanged.
- Saturation: event at max with no decrement: counter holds, `overflow` set. Event plus decrement at max: counter holds, no overflow.
- FSM states:
  - IDLE: if any `cnt`≠0 and `busy_in`=0, go to ISSUE. On that edge, set `sig_out[i]`=1 and decrement each selected channel. Otherwise stay.
  - ISSUE: `sig_out` high for exactly this cycle. Go to ARM; `sig_out` returns to 0.
  - ARM: if `busy_in`=1, go to DRAIN. If `HOLD_CYC` cycles pass with `busy_in`=0, set `arm_timeout` and go to IDLE.
  - DRAIN: when `busy_in`=0, go to IDLE.
- Channel selection (default): every channel with `cnt`≠0 is issued together.
- Events continue to be counted in all states.
- `ovf_clr` clears both sticky flags. If a new overflow or timeout occurs in the same cycle as `ovf_clr`, the set wins.
- `pending` is derived from next-state counters. It is 1 in the cycle after the first event is sampled and drops in the cycle after the final decrement.

## Timing
- Reset (async assert, sync deassert expected upstream): all counters 0, `sig_out`=0, `pending`=0, `overflow`=0, `arm_timeout`=0, state IDLE.
- Reset mid-operation clears everything immediately. Queued events are lost and `sig_out` drops without waiting for a clock.
- Latency, IDLE with `busy_in`=0: `event_in` sampled at edge n gives `sig_out` high from edge n+1 to edge n+2.
- Minimum spacing between issues: 4 cycles (ISSUE, ARM≥1, DRAIN≥1, IDLE≥1).
- `busy_in` already high in IDLE: no issue until it is low when sampled.
- `busy_in` rises during ISSUE: ignored there; ARM sees it on the next cycle.

## Configuration
- `PEQ_ROUND_ROBIN_ISSUE_EN` defined: each ISSUE selects exactly one channel, the first nonzero channel at or after a rotating pointer. The pointer moves to the channel after the one issued. The pointer resets to channel 0.
- Not defined: all nonzero channels are issued in the same ISSUE cycle, and no pointer exists.

## Test plan
- Single event on ch1, `busy_in` tied to a model asserting 1 cycle after `sig_out` for 4 cycles → `sig_out`=3'b010 for one cycle, 2 edges after the event. `pending` goes 0→1→0.
- 5 back-to-back events on ch0 while `busy_in`=1 → `cnt[0]`=5, no `sig_out`. After `busy_in` drops: exactly 5 single pulses, each separated by a full busy cycle.
- CNT_W=4: 17 events on ch2 with `busy_in` held 1 → `cnt`=15, `overflow`=1. `ovf_clr` → `overflow`=0.
- Events on ch0 and ch2 in the same cycle:
  - Default build → one `sig_out`=3'b101.
  - `PEQ_ROUND_ROBIN_ISSUE_EN` build → 3'b001, then 3'b100.
- `busy_in` never rises after an issue, HOLD_CYC=3 → `arm_timeout`=1 three cycles after ARM entry, and the FSM returns to IDLE.
- `rst` asserted during ISSUE with `cnt[1]`=3 → `sig_out`=0 immediately. After release all counters are 0 and no pulses follow.
